// File: rtl/battleship_board_renderer.sv
// battleship_board_renderer
// Game board for the VGA battleship display. Debounces five buttons, moves a cursor over the
// grid, records shots against a ship mask and renders the board into a registered pixel colour.
//
// Ports:
//   clk        pixel/system clock
//   reset      synchronous, active-high
//   bright     visible-area flag from the sync generator
//   hCount     horizontal scan position
//   vCount     vertical scan position
//   btn_l/r/u/d raw direction buttons; btn_c raw fire button
//   ship_mask  ship cells, bit row*GRID_COLS+col
//   rgb        registered pixel colour (colour for the scan position of the previous clock)
//   score      hit count (saturating)
//   shots      valid shots fired (saturating)
//   game_over  high once every ship cell has been hit
//
// Build option: define CURSOR_BLINK_EN to blink the cursor every 32 frames.
module battleship_board_renderer #(
  parameter int unsigned GRID_COLS    = 10,
  parameter int unsigned GRID_ROWS    = 10,
  parameter int unsigned CELL_W       = 64,
  parameter int unsigned CELL_H       = 48,
  parameter int unsigned GRID_LEFT    = 144,
  parameter int unsigned GRID_TOP     = 35,
  parameter int unsigned LINE_THICK   = 1,
  parameter int unsigned CURSOR_THICK = 2,
  parameter int unsigned DB_BITS      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bright,
  input  logic [9:0]                     hCount,
  input  logic [9:0]                     vCount,
  input  logic                           btn_l,
  input  logic                           btn_r,
  input  logic                           btn_u,
  input  logic                           btn_d,
  input  logic                           btn_c,
  input  logic [GRID_COLS*GRID_ROWS-1:0] ship_mask,
  output logic [11:0]                    rgb,
  output logic [15:0]                    score,
  output logic [15:0]                    shots,
  output logic                           game_over
);

  localparam int unsigned NCells = GRID_COLS * GRID_ROWS;
  localparam int unsigned IdxW   = (NCells > 1) ? $clog2(NCells) : 1;
  localparam int unsigned ColW   = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int unsigned RowW   = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;

  localparam logic [ColW-1:0] ColMax = ColW'(GRID_COLS - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(GRID_ROWS - 1);

  // Scan-domain constants, all in hCount/vCount width.
  localparam logic [9:0] GridLeftP = 10'(GRID_LEFT);
  localparam logic [9:0] GridTopP  = 10'(GRID_TOP);
  localparam logic [9:0] GridWP    = 10'(GRID_COLS * CELL_W + LINE_THICK);
  localparam logic [9:0] GridHP    = 10'(GRID_ROWS * CELL_H + LINE_THICK);
  localparam logic [9:0] CellWP    = 10'(CELL_W);
  localparam logic [9:0] CellHP    = 10'(CELL_H);
  localparam logic [9:0] LineP     = 10'(LINE_THICK);
  localparam logic [9:0] CurInP    = 10'(LINE_THICK + CURSOR_THICK);
  localparam logic [9:0] CurRP     = 10'(CELL_W - CURSOR_THICK);
  localparam logic [9:0] CurBP     = 10'(CELL_H - CURSOR_THICK);
  localparam logic [9:0] ColsP     = 10'(GRID_COLS);
  localparam logic [9:0] RowsP     = 10'(GRID_ROWS);

  // Button vector order: {c, d, u, r, l}
  localparam int unsigned BL = 0;
  localparam int unsigned BR = 1;
  localparam int unsigned BU = 2;
  localparam int unsigned BD = 3;
  localparam int unsigned BC = 4;

  typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

  state_e              st_q, st_d;
  logic [DB_BITS-1:0]  db_cnt_q;
  logic [4:0]          hist0_q, hist0_d, hist1_q, hist1_d, deb_q, deb_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [NCells-1:0]   hit_q, hit_d, miss_q, miss_d;
  logic [15:0]         score_q, score_d, shots_q, shots_d;
  logic [11:0]         rgb_q, rgb_d;

  logic                tick;
  logic [4:0]          btn_raw, deb_new, press;
  logic [IdxW-1:0]     cur_idx;

  assign btn_raw = {btn_c, btn_d, btn_u, btn_r, btn_l};
  // The counter wraps to zero on the edge that ends this cycle; that edge samples the buttons.
  assign tick    = &db_cnt_q;
  assign cur_idx = IdxW'(int'(row_q) * int'(GRID_COLS) + int'(col_q));

  // Game logic: debounce, cursor, shot map, FSM.
  always_comb begin
    st_d    = st_q;
    hist0_d = hist0_q;
    hist1_d = hist1_q;
    deb_d   = deb_q;
    col_d   = col_q;
    row_d   = row_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    score_d = score_q;
    shots_d = shots_q;

    // Debounced = current sample plus the two previous tick samples all high.
    deb_new = btn_raw & hist0_q & hist1_q;
    press   = tick ? (deb_new & ~deb_q) : 5'b0;
    if (tick) begin
      hist1_d = hist0_q;
      hist0_d = btn_raw;
      deb_d   = deb_new;
    end

    if (st_q != StOver) begin
      if (press[BL]) begin
        if (col_q != '0) col_d = col_q - 1'b1;
      end else if (press[BR]) begin
        if (col_q != ColMax) col_d = col_q + 1'b1;
      end
      if (press[BU]) begin
        if (row_q != '0) row_d = row_q - 1'b1;
      end else if (press[BD]) begin
        if (row_q != RowMax) row_d = row_q + 1'b1;
      end
    end

    // Shots use the pre-move cell (cur_idx comes from the current registers).
    if (st_q == StPlay && press[BC] && !hit_q[cur_idx] && !miss_q[cur_idx]) begin
      if (ship_mask[cur_idx]) begin
        hit_d[cur_idx] = 1'b1;
        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
      end else begin
        miss_d[cur_idx] = 1'b1;
      end
      if (shots_q != 16'hFFFF) shots_d = shots_q + 16'd1;
    end

    unique case (st_q)
      StIdle:  if (|ship_mask) st_d = StPlay;
      StPlay:  if ((ship_mask & ~hit_q) == '0) st_d = StOver;
      StOver:  st_d = StOver;
      default: st_d = StIdle;
    endcase
  end

  // Cursor visibility.
  logic cursor_vis;
`ifdef CURSOR_BLINK_EN
  logic [5:0] frame_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
    end else if (hCount == 10'd0 && vCount == 10'd0) begin
      frame_q <= frame_q + 6'd1;
    end
  end
  assign cursor_vis = ~frame_q[5];
`else
  assign cursor_vis = 1'b1;
`endif

  // Pixel decode.
  logic [9:0]      rel_x, rel_y, px_col, px_row, x_off, y_off;
  logic            x_in, y_in, x_line, y_line, in_grid, in_cell, cur_cell, cur_band, cursor_px;
  logic [IdxW-1:0] px_idx;

  always_comb begin
    rel_x   = hCount - GridLeftP;
    rel_y   = vCount - GridTopP;
    x_in    = (hCount >= GridLeftP) && (rel_x < GridWP);
    y_in    = (vCount >= GridTopP) && (rel_y < GridHP);
    px_col  = rel_x / CellWP;
    px_row  = rel_y / CellHP;
    x_off   = rel_x % CellWP;
    y_off   = rel_y % CellHP;
    // Column index GRID_COLS only occurs on the final right-hand line; same for rows.
    x_line  = (x_off < LineP) || (px_col >= ColsP);
    y_line  = (y_off < LineP) || (px_row >= RowsP);
    in_grid = x_in && y_in;
    in_cell = in_grid && !x_line && !y_line;
    px_idx  = IdxW'(px_row * ColsP + px_col);
    cur_cell  = in_cell && (px_col == 10'(col_q)) && (px_row == 10'(row_q));
    cur_band  = (x_off < CurInP) || (x_off >= CurRP) || (y_off < CurInP) || (y_off >= CurBP);
    cursor_px = cur_cell && cur_band && cursor_vis;

    rgb_d = 12'h000;
    if (!bright) begin
      rgb_d = 12'h000;
    end else if (cursor_px) begin
      rgb_d = 12'hFF0;
    end else if (in_grid && (x_line || y_line)) begin
      rgb_d = 12'hFFF;
    end else if (in_cell && hit_q[px_idx]) begin
      rgb_d = 12'hF00;
    end else if (in_cell && miss_q[px_idx]) begin
      rgb_d = 12'h888;
    end else if (in_cell) begin
      rgb_d = (st_q == StOver) ? 12'h0F0 : 12'h00F;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= StIdle;
      db_cnt_q <= '0;
      hist0_q  <= '0;
      hist1_q  <= '0;
      deb_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      score_q  <= '0;
      shots_q  <= '0;
      rgb_q    <= '0;
    end else begin
      st_q     <= st_d;
      db_cnt_q <= db_cnt_q + 1'b1;
      hist0_q  <= hist0_d;
      hist1_q  <= hist1_d;
      deb_q    <= deb_d;
      col_q    <= col_d;
      row_q    <= row_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      score_q  <= score_d;
      shots_q  <= shots_d;
      rgb_q    <= rgb_d;
    end
  end

  assign rgb       = rgb_q;
  assign score     = score_q;
  assign shots     = shots_q;
  assign game_over = (st_q == StOver);

endmodule

// File: doc/battleship_board_renderer.md
# battleship_board_renderer

Parametrised game-board block for the VGA battleship display: debounces five buttons, moves a cursor over a configurable grid, records shots against a ship mask in an on-chip shot map, and renders grid lines, cursor, hit/miss markers and game-over colouring for the VGA pixel stream. It sits between the VGA sync generator (supplies `bright`, `hCount`, `vCount`) and the board's RGB and seven-segment drivers (consume `rgb`, `score`).

## Interface
- `GRID_COLS`, 10, columns, 1..16
- `GRID_ROWS`, 10, rows, 1..16
- `CELL_W`, 64, cell width in pixels, line included
- `CELL_H`, 48, cell height in pixels, line included
- `GRID_LEFT`, 144, hCount of the left grid line
- `GRID_TOP`, 35, vCount of the top grid line
- `LINE_THICK`, 1, grid line thickness in pixels
- `CURSOR_THICK`, 2, cursor outline thickness, drawn inside the grid lines
- `DB_BITS`, 16, debounce sample period is 2^DB_BITS clocks
- `clk` in 1 pixel/system clock
- `reset` in 1 synchronous, active-high
- `bright` in 1 visible-area flag
- `hCount`, `vCount` in 10 each, scan position
- `btn_l`, `btn_r`, `btn_u`, `btn_d`, `btn_c` in 1 each, raw buttons; `btn_c` fires
- `ship_mask` in GRID_COLS*GRID_ROWS, bit `row*GRID_COLS+col` set = ship cell
- `rgb` out 12, registered pixel colour
- `score` out 16, hit count
- `shots` out 16, valid shots fired
- `game_over` out 1, high in state OVER

## Operation
- Debounce: free-running DB_BITS counter; tick when it wraps to 0. Per tick, each button shifts into a 3-bit history; debounced = all three ones; edge = debounced rising vs previous tick's debounced. All button-driven actions happen only on ticks.
- Cursor `col`, `row` reset to 0. L beats R; U beats D; horizontal and vertical moves on the same tick both apply. Saturate at 0 and GRID_COLS-1 / GRID_ROWS-1, no wrap.
- Shot map: two bit-vectors `hit_map`, `miss_map`, cleared on reset.
- FSM states IDLE, PLAY, OVER; reset to IDLE.
  - IDLE: movement allowed, fire ignored; go to PLAY on the first clock `ship_mask` is non-zero.
  - PLAY: fire edge on a cell with neither map bit set: set hit bit if `ship_mask` bit set (score+1) else miss bit; shots+1 in both cases. Fire on an already-shot cell: no change. Fire and move on the same tick: shot applies to the pre-move cell. Go to OVER the clock after `(ship_mask & ~hit_map) == 0`.
  - OVER: fire and movement ignored; leave only by reset.
- `score`, `shots` saturate at 16'hFFFF. `ship_mask` changes after IDLE are used live; no re-latching.
- Pixel priority (blank when `!bright`): cursor outline 12'hFF0 > grid line 12'hFFF > hit 12'hF00 > miss 12'h888 > unshot cell 12'h00F (12'h0F0 in OVER) > outside grid 12'h000.
- Cell decode: relative x = hCount-GRID_LEFT, col = x / CELL_W, offset = x % CELL_W; line when offset < LINE_THICK or at the final right/bottom line. Same for y. Grid extent is GRID_COLS*CELL_W + LINE_THICK wide.

## Timing
- `rgb` registered: colour for (hCount, vCount) at cycle n appears at n+1. Reset value 12'h000.
- Reset values: `score`=0, `shots`=0, `game_over`=0, cursor (0,0).
- Button edge to cursor/map update: on the tick that sees the third consecutive high sample plus one clock; visible from the next rendered pixel.
- `game_over` rises one clock after the last ship cell's hit bit is set.
- Reset mid-game clears all state on that edge; debounce histories clear to 0, so held buttons re-register as new presses.

## Configuration
- `CURSOR_BLINK_EN`: when defined, a frame counter (increments at hCount==0, vCount==0) toggles cursor visibility every 32 frames, reset visible. Without it the cursor is always drawn. Game logic is identical in both builds.

## Test plan
- DB_BITS=2, reset, press R for 12 ticks then release, press R 11 more times -> col steps 1..9 and stays 9; row 0.
- Button glitch high for 1 tick -> no move; high for 3 ticks -> exactly one move.
- ship_mask bit 0 only, fire at (0,0) -> score=1, shots=1, game_over=1 next clock; further fire/move ignored.
- ship_mask bit 11, fire at (0,0) twice -> shots=1, miss bit 0 set, score=0; pixel inside cell (0,0) reads 12'h888 one clock later.
- Scan pixel (GRID_LEFT, GRID_TOP+5) -> 12'hFFF; cursor interior edge (GRID_LEFT+1, GRID_TOP+1) -> 12'hFF0; `!bright` -> 12'h000.
- Assert reset while in PLAY with score=3 -> next clock score=0, shots=0, state IDLE, cursor (0,0).
